// File: rtl/q3_13_mac_accum.sv
// Q(3,13) multiply-accumulate: sums LEN products at full precision, then emits one
// rounded (half toward +inf), saturated Q(3,13) result per block over valid/ready.
module q3_13_mac_accum #(
    parameter int LEN   = 4,
    parameter int ACC_W = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(4096);
    localparam logic signed [ACC_W-1:0] MAX_R    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_R    = -(ACC_W'(32768));

    typedef enum logic [1:0] {ACCEPT, FLUSH, OUT, HOLD} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         count_q;
    logic signed [31:0]       prod_q;
    logic                     p_vld_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     in_ready_q;
    logic [15:0]              out_data_q;
    logic                     out_sat_q;
    logic                     out_valid_q;

    logic                     accept_d;
    logic signed [15:0]       a_s_d;
    logic signed [15:0]       b_s_d;
    logic signed [31:0]       prod_d;
    logic signed [ACC_W-1:0]  prod_ext_d;
    logic signed [ACC_W-1:0]  rnd_d;
    logic [15:0]              res_data_d;
    logic                     res_sat_d;

    assign accept_d   = in_valid & in_ready_q;
    assign a_s_d      = in_a;
    assign b_s_d      = in_b;
    assign prod_d     = a_s_d * b_s_d;
    assign prod_ext_d = {{(ACC_W-32){prod_q[31]}}, prod_q};
    // Adding half an output LSB before the arithmetic shift rounds ties toward +inf.
    assign rnd_d      = (acc_q + HALF_LSB) >>> 13;

    always_comb begin
        res_data_d = rnd_d[15:0];
        res_sat_d  = 1'b0;
        if (rnd_d > MAX_R) begin
            res_data_d = 16'h7FFF;
            res_sat_d  = 1'b1;
        end else if (rnd_d < MIN_R) begin
            res_data_d = 16'h8000;
            res_sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCEPT;
            count_q     <= '0;
            prod_q      <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_vld_q <= accept_d;
            if (accept_d) begin
                prod_q <= prod_d;
            end
            if (p_vld_q) begin
                acc_q <= acc_q + prod_ext_d;
            end

            case (state_q)
                ACCEPT: begin
                    in_ready_q <= 1'b1;
                    if (accept_d) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CNT_W'(LEN - 1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Product register drains one cycle after the last accept.
                    if (!p_vld_q) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    out_data_q  <= res_data_d;
                    out_sat_q   <= res_sat_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        count_q     <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACCEPT;
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
endmodule
